// File: rtl/vga_fb_reader_if.sv
// vga_fb_reader_if: frame-buffer read port plus the VGA connector pins.
// The reader drives the RAM address and all pins (master); the RAM and the
// connector side (slave) return the pixel data and observe the pins.
interface vga_fb_reader_if #(
    parameter int AW = 15,
    parameter int DW = 3
);
    logic [AW-1:0] mem_px_addr;
    logic [DW-1:0] mem_px_data;
    logic [3:0]    VGA_R;
    logic [3:0]    VGA_G;
    logic [3:0]    VGA_B;
    logic          VGA_Hsync_n;
    logic          VGA_Vsync_n;
    logic          frame_start;

    modport master (
        output mem_px_addr,
        input  mem_px_data,
        output VGA_R,
        output VGA_G,
        output VGA_B,
        output VGA_Hsync_n,
        output VGA_Vsync_n,
        output frame_start
    );

    modport slave (
        input  mem_px_addr,
        output mem_px_data,
        input  VGA_R,
        input  VGA_G,
        input  VGA_B,
        input  VGA_Hsync_n,
        input  VGA_Vsync_n,
        input  frame_start
    );
endinterface

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: read side of the RGB111 frame buffer.
// Generates VGA timing from the pixel clock, reads each stored pixel 2^SCALE_SH
// times horizontally and vertically (row base register, no multiplier), and
// expands the 3-bit pixel to RGB444. Counter -> pins latency is 3 clocks:
// address register, synchronous RAM read, colour register. Sync, active and
// frame_start are delayed by the same 3 stages so every pin lines up.
module vga_fb_reader #(
    parameter int AW       = 15,
    parameter int DW       = 3,
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int SCALE_SH = 2,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int H_SY     = 96,
    parameter int H_BP     = 48,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter int V_SY     = 2,
    parameter int V_BP     = 33
) (
    input  logic            PCLK,
    input  logic            rst,
    vga_fb_reader_if.master bus
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    // Last count value of each phase; the phase changes on the next clock.
    localparam logic [HW-1:0] H_END_ACT = HW'(H_ACT - 1);
    localparam logic [HW-1:0] H_END_FP  = HW'(H_ACT + H_FP - 1);
    localparam logic [HW-1:0] H_END_SY  = HW'(H_ACT + H_FP + H_SY - 1);
    localparam logic [HW-1:0] H_END_BP  = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_END_ACT = VW'(V_ACT - 1);
    localparam logic [VW-1:0] V_END_FP  = VW'(V_ACT + V_FP - 1);
    localparam logic [VW-1:0] V_END_SY  = VW'(V_ACT + V_FP + V_SY - 1);
    localparam logic [VW-1:0] V_END_BP  = VW'(V_TOT - 1);

    // Upscaled image extent on screen.
    localparam logic [HW-1:0] IMG_PW   = HW'(IMG_W << SCALE_SH);
    localparam logic [VW-1:0] IMG_PH   = VW'(IMG_H << SCALE_SH);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] ADDR_MAX = AW'(IMG_W * IMG_H - 1);
    localparam logic [VW-1:0] SC_MASK  = VW'((1 << SCALE_SH) - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    // Replicates one colour bit onto a 4-bit DAC channel.
    function automatic logic [3:0] expand(input logic px_bit);
        return {4{px_bit}};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    phase_t        h_phase;
    phase_t        v_phase;
    logic [AW-1:0] row_base;

    // Stage-1/2 delay registers for the raw timing signals.
    logic act_d1, act_d2;
    logic hs_d1,  hs_d2;
    logic vs_d1,  vs_d2;
    logic fs_d1,  fs_d2;

    // Combinational helpers
    logic          h_last;
    logic          v_last;
    logic [VW-1:0] v_next;
    logic          row_step;
    logic          in_image;
    logic          active_raw;
    logic [AW-1:0] addr_calc;
    logic [AW-1:0] addr_next;
    logic          hs_raw;
    logic          vs_raw;
    logic          fs_raw;

    // Decode raw timing, image region and the next read address from the counters.
    always_comb begin
        h_last     = (h_cnt == H_END_BP);
        v_last     = (v_cnt == V_END_BP);
        v_next     = v_cnt + VW'(1);
        // Advance the row base when the next line starts a new stored row,
        // but never past the last stored row so the address stays in range.
        row_step   = ((v_next & SC_MASK) == '0) && (v_next < IMG_PH);
        in_image   = (h_cnt < IMG_PW) && (v_cnt < IMG_PH);
        active_raw = in_image && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
        addr_calc  = row_base + AW'(h_cnt >> SCALE_SH);
        // Outside the image (or on a corrupted row base) read address 0.
        if (active_raw && (addr_calc <= ADDR_MAX)) begin
            addr_next = addr_calc;
        end else begin
            addr_next = '0;
        end
        hs_raw = (h_phase == PH_SYNC);
        vs_raw = (v_phase == PH_SYNC);
        fs_raw = (h_cnt == '0) && (v_cnt == '0);
    end

    // Beam counters, row base and the horizontal/vertical phase state machines.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
            h_phase  <= PH_ACTIVE;
            v_phase  <= PH_ACTIVE;
        end else begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt    <= '0;
                    row_base <= '0;
                end else begin
                    v_cnt <= v_next;
                    if (row_step) begin
                        row_base <= row_base + ROW_STEP;
                    end else begin
                        row_base <= row_base;
                    end
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end

            case (h_phase)
                PH_ACTIVE: h_phase <= (h_cnt == H_END_ACT) ? PH_FRONT  : PH_ACTIVE;
                PH_FRONT:  h_phase <= (h_cnt == H_END_FP)  ? PH_SYNC   : PH_FRONT;
                PH_SYNC:   h_phase <= (h_cnt == H_END_SY)  ? PH_BACK   : PH_SYNC;
                PH_BACK:   h_phase <= (h_cnt == H_END_BP)  ? PH_ACTIVE : PH_BACK;
                default:   h_phase <= PH_ACTIVE;
            endcase

            // The vertical phase only moves at the end of a line.
            if (h_last) begin
                case (v_phase)
                    PH_ACTIVE: v_phase <= (v_cnt == V_END_ACT) ? PH_FRONT  : PH_ACTIVE;
                    PH_FRONT:  v_phase <= (v_cnt == V_END_FP)  ? PH_SYNC   : PH_FRONT;
                    PH_SYNC:   v_phase <= (v_cnt == V_END_SY)  ? PH_BACK   : PH_SYNC;
                    PH_BACK:   v_phase <= (v_cnt == V_END_BP)  ? PH_ACTIVE : PH_BACK;
                    default:   v_phase <= PH_ACTIVE;
                endcase
            end else begin
                v_phase <= v_phase;
            end
        end
    end

    // Stage 1 and 2: registered RAM address and the matching timing delays.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            bus.mem_px_addr <= '0;
            act_d1 <= 1'b0;
            act_d2 <= 1'b0;
            hs_d1  <= 1'b0;
            hs_d2  <= 1'b0;
            vs_d1  <= 1'b0;
            vs_d2  <= 1'b0;
            fs_d1  <= 1'b0;
            fs_d2  <= 1'b0;
        end else begin
            bus.mem_px_addr <= addr_next;
            act_d1 <= active_raw;
            act_d2 <= act_d1;
            hs_d1  <= hs_raw;
            hs_d2  <= hs_d1;
            vs_d1  <= vs_raw;
            vs_d2  <= vs_d1;
            fs_d1  <= fs_raw;
            fs_d2  <= fs_d1;
        end
    end

    // Stage 3: colour expansion and sync/frame pins, black whenever blanking.
    always_ff @(posedge PCLK or posedge rst) begin
        if (rst) begin
            bus.VGA_R       <= 4'h0;
            bus.VGA_G       <= 4'h0;
            bus.VGA_B       <= 4'h0;
            bus.VGA_Hsync_n <= 1'b1;
            bus.VGA_Vsync_n <= 1'b1;
            bus.frame_start <= 1'b0;
        end else begin
            bus.VGA_R       <= act_d2 ? expand(bus.mem_px_data[DW-1]) : 4'h0;
            bus.VGA_G       <= act_d2 ? expand(bus.mem_px_data[DW-2]) : 4'h0;
            bus.VGA_B       <= act_d2 ? expand(bus.mem_px_data[DW-3]) : 4'h0;
            bus.VGA_Hsync_n <= ~hs_d2;
            bus.VGA_Vsync_n <= ~vs_d2;
            bus.frame_start <= fs_d2;
        end
    end

endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: directed bench for vga_fb_reader.
// u_big runs the default 640x480 timing (vector table, reset-mid-line sequence);
// u_sml runs a miniature timing so whole frames (vsync, frame period, last
// address, vertical wrap) fit in a short run and are compared cycle by cycle.
`timescale 1ns/1ps
module tb_vga_fb_reader;
    localparam int AW = 15;

    // Miniature configuration: 8x6 image -> 32x24 inside a 40x28 active area.
    localparam int S_HTOT = 56;
    localparam int S_VTOT = 35;

    logic PCLK     = 1'b0;
    logic rst      = 1'b1;
    logic ram_mode = 1'b1;   // big RAM model: 1 -> addr[2:0], 0 -> constant 3'b101

    int total = 0;
    int bad   = 0;
    int bcyc  = 0;

    vga_fb_reader_if #(.AW(AW), .DW(3)) big_if ();
    vga_fb_reader_if #(.AW(AW), .DW(3)) sml_if ();

    vga_fb_reader #(
        .AW(AW), .DW(3), .IMG_W(160), .IMG_H(120), .SCALE_SH(2),
        .H_ACT(640), .H_FP(16), .H_SY(96), .H_BP(48),
        .V_ACT(480), .V_FP(10), .V_SY(2), .V_BP(33)
    ) u_big (
        .PCLK(PCLK),
        .rst (rst),
        .bus (big_if.master)
    );

    vga_fb_reader #(
        .AW(AW), .DW(3), .IMG_W(8), .IMG_H(6), .SCALE_SH(2),
        .H_ACT(40), .H_FP(4), .H_SY(6), .H_BP(6),
        .V_ACT(28), .V_FP(2), .V_SY(2), .V_BP(3)
    ) u_sml (
        .PCLK(PCLK),
        .rst (rst),
        .bus (sml_if.master)
    );

    always #20 PCLK = ~PCLK;

    // Synchronous-read RAM models: data valid one clock after the address.
    always @(posedge PCLK) begin
        big_if.mem_px_data <= ram_mode ? big_if.mem_px_addr[2:0] : 3'b101;
        sml_if.mem_px_data <= sml_if.mem_px_addr[2:0];
    end

    typedef struct {
        int              h;
        int              v;
        logic            mode;
        logic [AW-1:0]   addr;
        logic [3:0]      r;
        logic [3:0]      g;
        logic [3:0]      b;
        logic            hs_n;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step_big();
        @(posedge PCLK);
        #1;
        bcyc++;
    endtask

    task automatic goto_big(input int target);
        while (bcyc < target) step_big();
    endtask

    // Independent address model for the miniature instance (uses a multiply).
    function automatic logic [AW-1:0] s_addr(input int p);
        int h;
        int v;
        h = p % S_HTOT;
        v = (p / S_HTOT) % S_VTOT;
        if (h < 32 && v < 24) return AW'((v / 4) * 8 + h / 4);
        else return '0;
    endfunction

    task automatic run_table();
        for (int i = 0; i < NVEC; i++) begin
            goto_big(vecs[i].v * 800 + vecs[i].h);
            ram_mode = vecs[i].mode;
            step_big();
            chk("addr", i, big_if.mem_px_addr, vecs[i].addr);
            step_big();
            step_big();
            chk("red",   i, big_if.VGA_R, vecs[i].r);
            chk("green", i, big_if.VGA_G, vecs[i].g);
            chk("blue",  i, big_if.VGA_B, vecs[i].b);
            chk("hsync", i, big_if.VGA_Hsync_n, vecs[i].hs_n);
            chk("vsync", i, big_if.VGA_Vsync_n, 1'b1);
            chk("fstart", i, big_if.frame_start, 1'b0);
        end
    endtask

    // Two full miniature frames plus pipeline fill, every output every cycle.
    task automatic run_small();
        int miss_a  = 0;
        int miss_p  = 0;
        int fs_cnt  = 0;
        int vs_low  = 0;
        logic [AW-1:0] ea;
        logic [2:0] d;
        logic [3:0] er, eg, eb;
        logic ehs, evs, efs;
        int p, h, v;
        for (int c = 0; c < 2 * S_HTOT * S_VTOT + 3; c++) begin
            if (c > 0) begin
                @(posedge PCLK);
                #1;
            end
            ea = (c == 0) ? '0 : s_addr(c - 1);
            if (c < 3) begin
                er = 4'h0; eg = 4'h0; eb = 4'h0; ehs = 1'b1; evs = 1'b1; efs = 1'b0;
            end else begin
                p = c - 3;
                h = p % S_HTOT;
                v = (p / S_HTOT) % S_VTOT;
                ea = ea;
                d  = s_addr(p) & AW'(7);
                er = d[2] ? 4'hF : 4'h0;
                eg = d[1] ? 4'hF : 4'h0;
                eb = d[0] ? 4'hF : 4'h0;
                ehs = !(h >= 44 && h < 50);
                evs = !(v >= 30 && v < 32);
                efs = (p % (S_HTOT * S_VTOT)) == 0;
            end
            if (sml_if.mem_px_addr !== ea) miss_a++;
            if (sml_if.VGA_R !== er || sml_if.VGA_G !== eg || sml_if.VGA_B !== eb ||
                sml_if.VGA_Hsync_n !== ehs || sml_if.VGA_Vsync_n !== evs ||
                sml_if.frame_start !== efs) miss_p++;
            if (sml_if.frame_start === 1'b1) fs_cnt++;
            if (c >= 3 && sml_if.VGA_Vsync_n === 1'b0) vs_low++;
            // Last stored pixel (31,23) -> address 47, one clock later.
            if (c == 23 * S_HTOT + 31 + 1) chk("sml_addr_max", c, sml_if.mem_px_addr, 47);
            // First line of the second frame: row base back to 0.
            if (c == S_HTOT * S_VTOT + 5 + 1) chk("sml_addr_wrap", c, sml_if.mem_px_addr, 1);
        end
        chk("sml_addr_sweep", 0, miss_a, 0);
        chk("sml_pin_sweep", 0, miss_p, 0);
        chk("sml_frame_starts", 0, fs_cnt, 2);
        chk("sml_vsync_low_cycles", 0, vs_low, 2 * 2 * S_HTOT);
    endtask

    // Reset asserted mid-line, then the first two lines after release.
    task automatic run_reset_seq();
        int miss = 0;
        int p, h;
        logic [3:0] er;
        logic ehs, efs;
        goto_big(15 * 800 + 300);
        rst = 1'b1;
        ram_mode = 1'b0;
        #1;
        chk("rst_addr",  0, big_if.mem_px_addr, 0);
        chk("rst_red",   0, big_if.VGA_R, 4'h0);
        chk("rst_green", 0, big_if.VGA_G, 4'h0);
        chk("rst_blue",  0, big_if.VGA_B, 4'h0);
        chk("rst_hsync", 0, big_if.VGA_Hsync_n, 1'b1);
        chk("rst_vsync", 0, big_if.VGA_Vsync_n, 1'b1);
        chk("rst_fstart", 0, big_if.frame_start, 1'b0);
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        rst = 1'b0;
        #1;
        for (int c = 0; c <= 1700; c++) begin
            if (c > 0) begin
                @(posedge PCLK);
                #1;
            end
            if (c < 3) begin
                er = 4'h0; ehs = 1'b1; efs = 1'b0;
            end else begin
                p = c - 3;
                h = p % 800;
                er  = (h < 640) ? 4'hF : 4'h0;
                ehs = !(h >= 656 && h < 752);
                efs = (p == 0);
            end
            if (big_if.VGA_R !== er || big_if.VGA_G !== 4'h0 || big_if.VGA_B !== er ||
                big_if.VGA_Hsync_n !== ehs || big_if.VGA_Vsync_n !== 1'b1 ||
                big_if.frame_start !== efs) miss++;
            if (c == 2)    chk("post_rst_red_c2", c, big_if.VGA_R, 4'h0);
            if (c == 3)    chk("post_rst_fstart_c3", c, big_if.frame_start, 1'b1);
            if (c == 3)    chk("post_rst_red_c3", c, big_if.VGA_R, 4'hF);
            if (c == 4)    chk("post_rst_fstart_c4", c, big_if.frame_start, 1'b0);
            if (c == 643)  chk("post_rst_blank_c643", c, big_if.VGA_B, 4'h0);
            if (c == 658)  chk("post_rst_hs_c658", c, big_if.VGA_Hsync_n, 1'b1);
            if (c == 659)  chk("post_rst_hs_c659", c, big_if.VGA_Hsync_n, 1'b0);
            if (c == 754)  chk("post_rst_hs_c754", c, big_if.VGA_Hsync_n, 1'b0);
            if (c == 755)  chk("post_rst_hs_c755", c, big_if.VGA_Hsync_n, 1'b1);
            if (c == 1459) chk("post_rst_hs_c1459", c, big_if.VGA_Hsync_n, 1'b0);
        end
        chk("post_rst_sweep", 0, miss, 0);
    endtask

    initial begin
        //          h    v   mode  addr      R     G     B    hs_n
        vecs[0]  = '{4,   0,  1'b1, 15'd1,   4'h0, 4'h0, 4'hF, 1'b1};
        vecs[1]  = '{10,  0,  1'b1, 15'd2,   4'h0, 4'hF, 4'h0, 1'b1};
        vecs[2]  = '{23,  0,  1'b1, 15'd5,   4'hF, 4'h0, 4'hF, 1'b1};
        vecs[3]  = '{28,  0,  1'b1, 15'd7,   4'hF, 4'hF, 4'hF, 1'b1};
        vecs[4]  = '{639, 0,  1'b1, 15'd159, 4'hF, 4'hF, 4'hF, 1'b1};
        vecs[5]  = '{645, 0,  1'b0, 15'd0,   4'h0, 4'h0, 4'h0, 1'b1};
        vecs[6]  = '{656, 0,  1'b0, 15'd0,   4'h0, 4'h0, 4'h0, 1'b0};
        vecs[7]  = '{751, 0,  1'b0, 15'd0,   4'h0, 4'h0, 4'h0, 1'b0};
        vecs[8]  = '{760, 0,  1'b0, 15'd0,   4'h0, 4'h0, 4'h0, 1'b1};
        vecs[9]  = '{3,   3,  1'b1, 15'd0,   4'h0, 4'h0, 4'h0, 1'b1};
        vecs[10] = '{0,   4,  1'b1, 15'd160, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[11] = '{7,   5,  1'b1, 15'd161, 4'h0, 4'h0, 4'hF, 1'b1};
        vecs[12] = '{12,  7,  1'b1, 15'd163, 4'h0, 4'hF, 4'hF, 1'b1};
        vecs[13] = '{20,  8,  1'b0, 15'd325, 4'hF, 4'h0, 4'hF, 1'b1};
        vecs[14] = '{100, 9,  1'b0, 15'd345, 4'hF, 4'h0, 4'hF, 1'b1};
        vecs[15] = '{700, 9,  1'b0, 15'd0,   4'h0, 4'h0, 4'h0, 1'b0};
        vecs[16] = '{799, 10, 1'b1, 15'd0,   4'h0, 4'h0, 4'h0, 1'b1};
        vecs[17] = '{9,   11, 1'b1, 15'd322, 4'h0, 4'hF, 4'h0, 1'b1};
        vecs[18] = '{636, 12, 1'b1, 15'd639, 4'hF, 4'hF, 4'hF, 1'b1};

        rst = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
        chk("init_rst_addr",  0, big_if.mem_px_addr, 0);
        chk("init_rst_hsync", 0, big_if.VGA_Hsync_n, 1'b1);
        chk("init_rst_red",   0, big_if.VGA_R, 4'h0);
        @(negedge PCLK);
        rst = 1'b0;
        #1;
        bcyc = 0;
        fork
            run_table();
            run_small();
        join
        run_reset_seq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
